// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single-port data RAM between the Hack CPU and one DMA requester.
// The CPU owns the RAM by default. DMA gets a burst of up to BURST_LEN words
// when the CPU is not touching memory, or after DMA has waited MAX_WAIT cycles.
// While DMA owns the RAM, cpu_stall freezes the CPU. After every burst the CPU
// gets at least one cycle of ownership, so it always makes progress.
//
// Ports
//   clk         in   system clock, all state on posedge
//   reset       in   asynchronous, active-low reset
//   cpu_addr    in   CPU addressM
//   cpu_wdata   in   CPU outM
//   cpu_we      in   CPU writeM
//   cpu_mem_en  in   current CPU instruction reads or writes M
//   cpu_rdata   out  to CPU inM (= ram_rdata)
//   cpu_stall   out  CPU must hold all state this cycle
//   dma_req     in   DMA has a word to transfer this cycle
//   dma_addr    in   DMA address
//   dma_wdata   in   DMA write data
//   dma_we      in   DMA write (1) / read (0)
//   dma_gnt     out  word on dma_* accepted this cycle
//   dma_rvalid  out  dma_rdata valid (read accepted previous cycle)
//   dma_rdata   out  read data to DMA (= ram_rdata)
//   ram_addr    out  muxed RAM address
//   ram_wdata   out  muxed RAM write data
//   ram_we      out  muxed RAM write enable
//   ram_rdata   in   synchronous RAM read data, 1-cycle latency
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 8,
   parameter int MAX_WAIT  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_mem_en,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_we,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic [BEAT_W-1:0] w_beat_nxt;
   logic              r_dma_rvalid;
   logic              w_wait_full;
   logic              w_last_beat;

   assign w_wait_full = (r_wait_cnt == WAIT_W'(MAX_WAIT));
   assign w_last_beat = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));

   // State register. An asynchronous reset abandons any burst and also kills
   // the rvalid of a read that was granted in the same cycle.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= CPU_OWN;
         r_wait_cnt   <= '0;
         r_beat_cnt   <= '0;
         r_dma_rvalid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wait_cnt   <= w_wait_nxt;
         r_beat_cnt   <= w_beat_nxt;
         r_dma_rvalid <= dma_gnt && !dma_we;
      end
   end

   // Next-state and counter logic.
   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_beat_nxt  = r_beat_cnt;
      unique case (r_state)
         CPU_OWN: begin
            // Wait counter measures how long DMA has been kept out; it
            // saturates so the forced-grant condition stays true.
            if (!dma_req) begin
               w_wait_nxt = '0;
            end else if (!w_wait_full) begin
               w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            end
            if (dma_req && (!cpu_mem_en || w_wait_full)) begin
               w_state_nxt = DMA_OWN;
            end
         end
         DMA_OWN: begin
            // Leaving after the last beat (rather than on the cycle after it)
            // is what hands the CPU at least one cycle between bursts.
            if (!dma_req || w_last_beat) begin
               w_state_nxt = CPU_OWN;
               w_beat_nxt  = '0;
               w_wait_nxt  = '0;
            end else begin
               w_beat_nxt  = r_beat_cnt + BEAT_W'(1);
            end
         end
         default: begin
            w_state_nxt = CPU_OWN;
         end
      endcase
   end

   // Output decode. Stall depends only on the registered state, so dma_req
   // never reaches cpu_stall combinationally.
   always_comb begin
      cpu_stall = 1'b0;
      dma_gnt   = 1'b0;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we && reset;
      if (r_state == DMA_OWN) begin
         cpu_stall = 1'b1;
         dma_gnt   = dma_req;
         ram_addr  = dma_addr;
         ram_wdata = dma_wdata;
         ram_we    = dma_we && dma_req;
      end
   end

   assign dma_rvalid = r_dma_rvalid;
   assign dma_rdata  = ram_rdata;
   assign cpu_rdata  = ram_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter with a behavioural synchronous RAM.
// DMA words are pushed to a write or read scoreboard queue when presented and
// popped by a negedge monitor when the DUT grants the write or returns data.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int ADDR_W    = 15;
   localparam int DATA_W    = 16;
   localparam int BURST_LEN = 8;
   localparam int MAX_WAIT  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we;
   logic              cpu_mem_en;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_we;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN),
      .MAX_WAIT  (MAX_WAIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_mem_en (cpu_mem_en),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_we     (dma_we),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata)
   );

   // Synchronous single-port RAM, read-before-write, 1-cycle read latency.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   int n_vec  = 0;
   int n_miss = 0;

   logic [ADDR_W+DATA_W-1:0] wq [$];   // expected DMA writes {addr, data}
   logic [DATA_W-1:0]        rq [$];   // expected DMA read data
   logic [ADDR_W+DATA_W-1:0] mon_w;
   logic [DATA_W-1:0]        mon_r;

   int k;          // index of the DMA word currently presented
   int presented;  // last index pushed to a scoreboard

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: a granted DMA write must match the oldest queued
   // write; each rvalid must return the oldest queued read data.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (dma_gnt && dma_we) begin
            check("dma_wr_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
               mon_w = wq.pop_front();
               check("dma_wr_word", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, mon_w}));
            end
         end
         if (dma_rvalid) begin
            check("dma_rd_expected", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
               mon_r = rq.pop_front();
               check("dma_rd_data", 32'(dma_rdata), 32'(mon_r));
            end
         end
      end
   end

   task automatic dma_start();
      k         = 0;
      presented = -1;
   endtask

   // One clock of DMA activity: drive after the posedge, check at negedge.
   task automatic dma_cycle(input string lbl, input bit req, input bit we,
                            input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] dbase,
                            input bit exp_gnt, input bit exp_stall);
      @(posedge clk);
      #1;
      dma_req   = req;
      dma_we    = we;
      dma_addr  = base + ADDR_W'(k);
      dma_wdata = dbase + DATA_W'(k);
      if (req && (k != presented)) begin
         if (we) wq.push_back({dma_addr, dma_wdata});
         else    rq.push_back(dbase + DATA_W'(k));
         presented = k;
      end
      @(negedge clk);
      check({lbl, "_gnt"},    32'(dma_gnt),   32'(exp_gnt));
      check({lbl, "_stall"},  32'(cpu_stall), 32'(exp_stall));
      check({lbl, "_ram_we"}, 32'(ram_we),    32'(exp_gnt && we));
      if (exp_gnt) check({lbl, "_ram_addr"}, 32'(ram_addr), 32'(base + ADDR_W'(k)));
      if (dma_gnt) k++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit t2_req   [6] = '{1, 1, 1, 1, 0, 0};
      bit t2_gnt   [6] = '{0, 1, 1, 1, 0, 0};
      bit t2_stall [6] = '{0, 1, 1, 1, 1, 0};
      bit t5_req   [5] = '{1, 1, 1, 0, 0};
      bit t5_gnt   [5] = '{0, 1, 1, 0, 0};
      bit t5_stall [5] = '{0, 1, 1, 1, 0};

      mem[15'h0010] = 16'hBEEF;
      for (int i = 0; i < 5; i++) mem[15'h0100 + 15'(i)] = 16'hA000 + 16'(i);

      // ---- 1: reset held with DMA requesting and CPU writing ----------------
      reset      = 1'b0;
      cpu_addr   = 15'h1234;
      cpu_wdata  = 16'h5555;
      cpu_we     = 1'b1;
      cpu_mem_en = 1'b0;
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = 15'h7FFF;
      dma_wdata  = 16'hDEAD;
      repeat (2) @(negedge clk);
      check("rst_stall",  32'(cpu_stall),  32'd0);
      check("rst_gnt",    32'(dma_gnt),    32'd0);
      check("rst_ram_we", 32'(ram_we),     32'd0);
      check("rst_rvalid", 32'(dma_rvalid), 32'd0);
      dma_req = 1'b0;
      cpu_we  = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      check("post_rst_stall", 32'(cpu_stall), 32'd0);
      check("post_rst_addr",  32'(ram_addr),  32'h1234);

      // CPU write then read back through the RAM while CPU owns it.
      @(posedge clk); #1;
      cpu_mem_en = 1'b1;
      cpu_we     = 1'b1;
      cpu_addr   = 15'h0042;
      cpu_wdata  = 16'h1357;
      @(negedge clk);
      check("cpu_wr_we",   32'(ram_we),    32'd1);
      check("cpu_wr_addr", 32'(ram_addr),  32'h0042);
      check("cpu_wr_data", 32'(ram_wdata), 32'h1357);
      @(posedge clk); #1;
      cpu_we = 1'b0;
      @(posedge clk); #1;
      cpu_mem_en = 1'b0;
      @(negedge clk);
      check("cpu_rd_data", 32'(cpu_rdata), 32'h1357);

      // ---- 2: idle CPU, 3-word DMA write burst at 0x4000 -------------------
      dma_start();
      for (int i = 0; i < 6; i++)
         dma_cycle("t2", t2_req[i], 1'b1, 15'h4000, 16'h1110, t2_gnt[i], t2_stall[i]);
      for (int i = 0; i < 3; i++)
         check("t2_mem", 32'(mem[15'h4000 + 15'(i)]), 32'(16'h1110 + 16'(i)));

      // ---- 4: DMA read of preloaded 0x0010 ---------------------------------
      dma_start();
      dma_cycle("t4", 1'b1, 1'b0, 15'h0010, 16'hBEEF, 1'b0, 1'b0);
      dma_cycle("t4", 1'b1, 1'b0, 15'h0010, 16'hBEEF, 1'b1, 1'b1);
      check("t4_rvalid_early", 32'(dma_rvalid), 32'd0);
      dma_cycle("t4", 1'b0, 1'b0, 15'h0010, 16'hBEEF, 1'b0, 1'b1);
      check("t4_rvalid",    32'(dma_rvalid), 32'd1);
      check("t4_rdata",     32'(dma_rdata),  32'hBEEF);
      check("t4_cpu_rdata", 32'(cpu_rdata),  32'hBEEF);
      dma_cycle("t4", 1'b0, 1'b0, 15'h0010, 16'hBEEF, 1'b0, 1'b0);
      check("t4_rvalid_done", 32'(dma_rvalid), 32'd0);

      // ---- 5: write burst dropped after 2 beats ----------------------------
      dma_start();
      for (int i = 0; i < 5; i++) begin
         dma_cycle("t5", t5_req[i], 1'b1, 15'h5000, 16'h2220, t5_gnt[i], t5_stall[i]);
         if (i == 3) check("t5_beats_at_drop", 32'(dut.r_beat_cnt), 32'd2);
      end
      check("t5_beat_cnt", 32'(dut.r_beat_cnt), 32'd0);
      check("t5_wait_cnt", 32'(dut.r_wait_cnt), 32'd0);

      // ---- 3: busy CPU, DMA always requesting: forced bursts ---------------
      // A CPU_OWN cycle with wait count 0..MAX_WAIT is spent before each grant,
      // i.e. MAX_WAIT+1 CPU cycles, then BURST_LEN granted beats.
      cpu_mem_en = 1'b1;
      dma_start();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i <= MAX_WAIT; i++)
            dma_cycle("t3_cpu", 1'b1, 1'b1, 15'h0300, 16'hC000, 1'b0, 1'b0);
         for (int b = 0; b < BURST_LEN; b++)
            dma_cycle("t3_dma", 1'b1, 1'b1, 15'h0300, 16'hC000, 1'b1, 1'b1);
      end
      dma_cycle("t3_progress", 1'b1, 1'b1, 15'h0300, 16'hC000, 1'b0, 1'b0);
      check("t3_words", 32'(k), 32'(2 * BURST_LEN));
      void'(wq.pop_back());   // word presented but never granted
      dma_cycle("t3_idle", 1'b0, 1'b1, 15'h0300, 16'hC000, 1'b0, 1'b0);
      cpu_mem_en = 1'b0;

      // ---- 6: async reset during beat 4 of a read burst --------------------
      dma_start();
      dma_cycle("t6", 1'b1, 1'b0, 15'h0100, 16'hA000, 1'b0, 1'b0);
      for (int b = 0; b < 5; b++)
         dma_cycle("t6", 1'b1, 1'b0, 15'h0100, 16'hA000, 1'b1, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_gnt_drop",   32'(dma_gnt),   32'd0);
      check("t6_stall_drop", 32'(cpu_stall), 32'd0);
      void'(rq.pop_back());   // abandoned read of beat 4
      check("t6_rq_empty", 32'(rq.size()), 32'd0);
      @(negedge clk);
      check("t6_rvalid_rst", 32'(dma_rvalid), 32'd0);
      dma_req = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      check("t6_rvalid_after", 32'(dma_rvalid), 32'd0);
      check("t6_stall_after",  32'(cpu_stall),  32'd0);

      check("wq_drained", 32'(wq.size()), 32'd0);
      check("rq_drained", 32'(rq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
